// File: rtl/branch_fwd_ctrl.sv
// branch_fwd_ctrl
//   Hazard and forwarding control for instructions that consume register
//   operands in ID (conditional branches and jalr). A three-entry scoreboard
//   mirrors the destination registers of the instructions currently in EX,
//   MEM and WB. It is used to pick comparator operand sources, to stall ID
//   when a producer is still in EX, and to flush IF/ID on a taken branch.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   id_valid/id_early     ID holds a valid instruction / it reads operands in ID
//   id_is_branch          ID instruction is a conditional branch
//   id_rs1/id_rs2         source register indices
//   id_use_rs1/id_use_rs2 source register is actually read
//   id_rd/id_we/id_is_load destination info of the ID instruction
//   ext_stall             global freeze; scoreboard and counter hold
//   br_taken              comparator result for the ID instruction
//   rs1_forwarding/rs2_forwarding
//                         00 regfile, 01 MEM ALU, 10 WB data, 11 MEM load data
//   stall_id/bubble_ex/flush_if  pipeline control
//   stall_cnt             saturating count of stall cycles
//
// Handshake: none. All control outputs are combinational from the
// scoreboard and the current ID inputs and are valid in the same cycle.
module branch_fwd_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_early,
    input  logic             id_is_branch,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ext_stall,
    input  logic             br_taken,
    output logic [1:0]       rs1_forwarding,
    output logic [1:0]       rs2_forwarding,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic [CNT_W-1:0] stall_cnt
);

    // Scoreboard entries {v, rd, we, ld} for EX, MEM, WB
    logic       ex_v_q,  mem_v_q,  wb_v_q;
    logic [4:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic       ex_we_q, mem_we_q, wb_we_q;
    logic       ex_ld_q, mem_ld_q, wb_ld_q;

    logic       ex_v_d;
    logic [4:0] ex_rd_d;
    logic       ex_we_d;
    logic       ex_ld_d;

    logic [CNT_W-1:0] stall_cnt_q;

    function automatic logic is_hit(input logic v, input logic we,
                                    input logic [4:0] rd, input logic [4:0] r);
        return v & we & (rd == r) & (r != 5'd0);
    endfunction

    // Priority: MEM (ALU or load data) beats WB; x0 never hits.
    function automatic logic [1:0] fwd_sel(input logic use_r, input logic mem_hit,
                                           input logic mem_ld, input logic wb_hit);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r) begin
            if (mem_hit)     sel = mem_ld ? 2'b11 : 2'b01;
            else if (wb_hit) sel = 2'b10;
        end
        return sel;
    endfunction

    logic ex_hit_rs1, ex_hit_rs2;
    logic mem_hit_rs1, mem_hit_rs2;
    logic wb_hit_rs1, wb_hit_rs2;

    always_comb begin
        ex_hit_rs1  = is_hit(ex_v_q,  ex_we_q,  ex_rd_q,  id_rs1);
        ex_hit_rs2  = is_hit(ex_v_q,  ex_we_q,  ex_rd_q,  id_rs2);
        mem_hit_rs1 = is_hit(mem_v_q, mem_we_q, mem_rd_q, id_rs1);
        mem_hit_rs2 = is_hit(mem_v_q, mem_we_q, mem_rd_q, id_rs2);
        wb_hit_rs1  = is_hit(wb_v_q,  wb_we_q,  wb_rd_q,  id_rs1);
        wb_hit_rs2  = is_hit(wb_v_q,  wb_we_q,  wb_rd_q,  id_rs2);

        rs1_forwarding = fwd_sel(id_use_rs1, mem_hit_rs1, mem_ld_q, wb_hit_rs1);
        rs2_forwarding = fwd_sel(id_use_rs2, mem_hit_rs2, mem_ld_q, wb_hit_rs2);

        // A producer in EX has no value to forward yet (ALU result is not
        // available in ID, load data even less), so wait one cycle; by then
        // it sits in MEM and forwards as 01 or 11.
        stall_id  = id_valid & id_early &
                    ((id_use_rs1 & ex_hit_rs1) | (id_use_rs2 & ex_hit_rs2));
        bubble_ex = stall_id & ~ext_stall;
        // Comparator operands are stale while stalled, so ignore br_taken.
        flush_if  = id_valid & id_is_branch & br_taken & ~stall_id & ~ext_stall;

        ex_v_d  = bubble_ex ? 1'b0 : id_valid;
        ex_rd_d = id_rd;
        ex_we_d = id_we;
        ex_ld_d = id_is_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= 5'd0;
            ex_we_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= 5'd0;
            mem_we_q <= 1'b0;
            mem_ld_q <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= 5'd0;
            wb_we_q  <= 1'b0;
            wb_ld_q  <= 1'b0;
        end else if (!ext_stall) begin
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
            wb_we_q  <= mem_we_q;
            wb_ld_q  <= mem_ld_q;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_we_q <= ex_we_q;
            mem_ld_q <= ex_ld_q;
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            ex_we_q  <= ex_we_d;
            ex_ld_q  <= ex_ld_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bubble_ex && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
module tb_branch_fwd_ctrl;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             id_valid, id_early, id_is_branch;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_we, id_is_load;
  logic             ext_stall, br_taken;
  logic [1:0]       rs1_forwarding, rs2_forwarding;
  logic             stall_id, bubble_ex, flush_if;
  logic [CNT_W-1:0] stall_cnt;

  branch_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_early(id_early), .id_is_branch(id_is_branch),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .ext_stall(ext_stall), .br_taken(br_taken),
    .rs1_forwarding(rs1_forwarding), .rs2_forwarding(rs2_forwarding),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .stall_cnt(stall_cnt)
  );

  // ---------------- reference model ----------------
  // inflight[0] is the youngest instruction past ID (EX), [1] MEM, [2] WB.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ent_t;

  ent_t inflight[$];
  int   m_cnt;
  int   n_assert;
  int   n_fail;

  function automatic ent_t empty_ent();
    ent_t e;
    e = '0;
    return e;
  endfunction

  function automatic void model_reset();
    inflight.delete();
    for (int i = 0; i < 3; i++) inflight.push_back(empty_ent());
    m_cnt = 0;
  endfunction

  // Does the instruction at pipeline depth s produce register r?
  function automatic bit produces(int s, logic [4:0] r);
    return inflight[s].v && inflight[s].we && inflight[s].rd == r && r != 0;
  endfunction

  function automatic bit exp_stall();
    return id_valid && id_early &&
           ((id_use_rs1 && produces(0, id_rs1)) || (id_use_rs2 && produces(0, id_rs2)));
  endfunction

  function automatic logic [1:0] exp_sel(logic use_r, logic [4:0] r);
    if (!use_r) return 2'b00;
    if (produces(1, r)) return inflight[1].ld ? 2'b11 : 2'b01;
    if (produces(2, r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_flush();
    return id_valid && id_is_branch && br_taken && !exp_stall() && !ext_stall;
  endfunction

  // Apply one rising edge to the model using the inputs held during it.
  function automatic void model_step();
    ent_t n;
    bit   st;
    st = exp_stall();
    if (ext_stall) return;
    n = empty_ent();
    if (!st) begin
      n.v  = id_valid;
      n.rd = id_rd;
      n.we = id_we;
      n.ld = id_is_load;
    end
    inflight.push_front(n);
    void'(inflight.pop_back());
    if (st && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  // ---------------- scoreboard checks ----------------
  task automatic check_now(input string tag);
    bit         e_st;
    logic [1:0] e1, e2;
    e_st = exp_stall();
    e1 = exp_sel(id_use_rs1, id_rs1);
    e2 = exp_sel(id_use_rs2, id_rs2);
    n_assert++;
    assert (stall_id === e_st) else begin
      n_fail++; $error("FAIL %s stall_id got %0b exp %0b", tag, stall_id, e_st);
    end
    n_assert++;
    assert (bubble_ex === (e_st && !ext_stall)) else begin
      n_fail++; $error("FAIL %s bubble_ex got %0b exp %0b", tag, bubble_ex, e_st && !ext_stall);
    end
    n_assert++;
    assert (flush_if === exp_flush()) else begin
      n_fail++; $error("FAIL %s flush_if got %0b exp %0b", tag, flush_if, exp_flush());
    end
    n_assert++;
    assert (stall_cnt === CNT_W'(m_cnt)) else begin
      n_fail++; $error("FAIL %s stall_cnt got %0d exp %0d", tag, stall_cnt, m_cnt);
    end
    if (!e_st) begin
      n_assert++;
      assert (rs1_forwarding === e1) else begin
        n_fail++; $error("FAIL %s rs1_forwarding got %b exp %b", tag, rs1_forwarding, e1);
      end
      n_assert++;
      assert (rs2_forwarding === e2) else begin
        n_fail++; $error("FAIL %s rs2_forwarding got %b exp %b", tag, rs2_forwarding, e2);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic early, input logic br,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic taken, input logic ext);
    id_valid = v;    id_early = early; id_is_branch = br;
    id_rs1 = rs1;    id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd;      id_we = we;       id_is_load = ld;
    br_taken = taken; ext_stall = ext;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs are already applied; check mid-cycle, then take the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ALU op writing rd (not early)
  task automatic alu(input logic [4:0] rd);
    drive(1, 0, 0, 0, 0, 0, 0, rd, 1, 0, 0, 0);
  endtask

  task automatic load(input logic [4:0] rd);
    drive(1, 0, 0, 0, 0, 0, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic branch(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic taken, input logic ext);
    drive(1, 1, 1, rs1, rs2, 1, 1, 0, 0, 0, taken, ext);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_assert = 0;
    n_fail = 0;
    rst = 1'b1;
    idle();
    model_reset();
    #2;
    check_now("reset");
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle("idle");

    // add x5 in EX, beq x5,x6: one stall then MEM ALU forward
    alu(5);             cycle("add_x5");
    branch(5, 6, 0, 0); cycle("beq_stall");
    n_assert++;
    assert (stall_cnt === 4'd1) else begin
      n_fail++; $error("FAIL cnt_after_beq got %0d exp 1", stall_cnt);
    end
    branch(5, 6, 0, 0); cycle("beq_fwd01");
    idle(); cycle("idle"); cycle("idle");

    // lw x7 in EX, bne x0,x7: one stall then load-data forward
    load(7);            cycle("lw_x7");
    branch(0, 7, 0, 0); cycle("bne_stall");
    branch(0, 7, 0, 0); cycle("bne_fwd11");
    idle(); cycle("idle"); cycle("idle");

    // x3 in MEM and WB: MEM wins, no stall
    alu(3); cycle("addi1");
    alu(3); cycle("addi2");
    idle(); cycle("gap");
    alu(9); cycle("other");
    branch(3, 3, 0, 0); cycle("blt_wb_only");
    idle(); cycle("idle"); cycle("idle");
    alu(3); cycle("addi_a");
    alu(3); cycle("addi_b");
    idle(); cycle("bubble");
    branch(3, 3, 0, 0); cycle("blt_mem_wb");

    // taken branch: one-cycle flush, then freeze for 3 cycles
    branch(3, 3, 1, 0); cycle("beq_taken");
    idle();             cycle("after_taken");
    alu(4); cycle("addi_x4");
    idle(); cycle("x4_to_mem");
    for (int i = 0; i < 3; i++) begin
      branch(4, 4, 1, 1); cycle("frozen");
    end
    branch(4, 4, 1, 0); cycle("unfrozen");
    idle(); cycle("idle");

    // reset in the middle of a load hazard
    load(8);            cycle("lw_x8");
    branch(8, 1, 0, 0);
    #2;
    check_now("pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    check_now("mid_rst");
    #1;
    rst = 1'b0;
    cycle("post_rst");
    idle(); cycle("idle");

    // saturate the stall counter
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      load(9);            cycle("sat_lw");
      branch(9, 0, 0, 0); cycle("sat_stall");
      branch(9, 0, 0, 0); cycle("sat_fwd");
    end
    n_assert++;
    assert (stall_cnt === 4'd15) else begin
      n_fail++; $error("FAIL cnt_saturated got %0d exp 15", stall_cnt);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_fwd_ctrl.md
Name: branch_fwd_ctrl

Overview:
- Hazard and forwarding controller for ID-stage consumers of the branch comparator: branches and jalr.
- Keeps an internal scoreboard of the destination registers of instructions in EX, MEM and WB.
- Drives the 2-bit operand-select codes consumed by the ID-stage branch comparator.
- Drives the ID stall, the EX bubble and the IF/ID flush on a taken branch.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_early  in  1  ID instruction reads operands in ID (branch or jalr).
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_rs1  in  5  source register 1 index.
- id_rs2  in  5  source register 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  5  destination register index.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- ext_stall  in  1  global pipeline freeze (memory wait); the scoreboard holds.
- br_taken  in  1  comparator result for the current ID instruction.
- rs1_forwarding  out  2  rs1 select: 00 regfile, 01 MEM ALU result, 10 WB rd_data, 11 MEM load data.
- rs2_forwarding  out  2  rs2 select, same encoding as rs1_forwarding.
- stall_id  out  1  hold PC and IF/ID this cycle.
- bubble_ex  out  1  insert a NOP into ID/EX this cycle.
- flush_if  out  1  kill the IF/ID instruction (taken branch).
- stall_cnt  out  CNT_W  count of stall cycles.

Behaviour:
- Scoreboard: three stage entries, EX, MEM and WB, each holding {v, rd, we, ld}.
  - An entry is a hit for register r when v & we & rd==r & r!=0.
- Per-cycle update when ext_stall=0:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble_ex ? {v=0} : {id_valid, id_rd, id_we, id_is_load}.
  - When ext_stall=1, all entries hold.
- Async reset: all entries v=0 and stall_cnt=0. Reset mid-stall drops the pending hazard immediately.
- Forwarding select, computed per operand X with rsX = id_rsX and only when id_use_rsX=1; otherwise 00. Priority order:
  1. MEM hit with ld=0 -> 01.
  2. MEM hit with ld=1 -> 11.
  3. WB hit -> 10.
  4. Otherwise -> 00.
  - Forwarding outputs are combinational from scoreboard state and current inputs, valid in the same cycle.
  - x0 (index 0) always yields 00.
- Stall: stall_id = id_valid & id_early & (EX hit on rs1 with id_use_rs1, or EX hit on rs2 with id_use_rs2).
  - A hit with EX.ld=0 stalls 1 cycle, then resolves as 01.
  - A hit with EX.ld=1 stalls 1 cycle, then resolves as 11.
  - No case requires 2 stall cycles.
- bubble_ex = stall_id & ~ext_stall.
- While stall_id=1, the forwarding outputs are don't-care; the bench must not check them.
- flush_if = id_valid & id_is_branch & br_taken & ~stall_id & ~ext_stall.
  - br_taken is ignored while stalled, since its operands are stale.
- stall_cnt: increments on each edge where stall_id & ~ext_stall; saturates at all-ones.
- Output values when all inputs are idle after reset: all outputs 0.
- Non-early instructions (id_early=0) never cause stall_id; they are still tracked in the scoreboard.

Test Plan:
- add x5 in EX, then beq x5,x6 in ID -> cycle 0: stall_id=1, bubble_ex=1; cycle 1: rs1_forwarding=01, rs2_forwarding=00, stall_id=0; stall_cnt=1.
- lw x7 in EX, then bne x0,x7 in ID -> cycle 0: stall 1 cycle; cycle 1: rs2_forwarding=11, rs1_forwarding=00 (x0 never forwards).
- addi x3 in MEM and addi x3 in WB, then blt x3,x3 -> both selects 01 (MEM beats WB); no stall.
- Taken beq with no hazard, br_taken=1 -> flush_if=1 for exactly 1 cycle; with ext_stall=1 held 3 cycles -> flush_if=0 and scoreboard frozen, so the same selects persist.
- Load hazard active, rst pulsed mid-cycle -> stall_id drops asynchronously to 0, selects 00, stall_cnt=0.
- Force 2^CNT_W - 1 stall cycles with CNT_W=4 (15 cycles), then 3 more -> stall_cnt holds 15.
